// File: rtl/uart_time_set_rx.sv
// UART receiver with a "T MM SS CR" frame parser.
// Presents BCD minutes/seconds digits with a one-cycle load pulse.
module uart_time_set_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       load,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       frame_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [2:0] {
        P_WAIT_T, P_M10, P_M1, P_S10, P_S1, P_CR
    } p_state_t;

    r_state_t r_state, r_next;
    p_state_t p_state, p_next;

    logic          rx_meta, rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          cnt_clr, bit_take, stop_ok, stop_bad;

    logic [2:0] m10_sh, s10_sh;
    logic [3:0] m1_sh, s1_sh;
    logic       wr_m10, wr_m1, wr_s10, wr_s1, ld, perr;
    logic       is_t, is_cr, is_tens, is_ones;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        r_next   = r_state;
        cnt_clr  = 1'b0;
        bit_take = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                cnt_clr = 1'b1;
                if (!rxs) r_next = R_START;
            end
            R_START: begin
                if (cnt == HALF) begin
                    cnt_clr = 1'b1;
                    r_next  = rxs ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt == FULL) begin
                    cnt_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (bit_idx == 3'd7) r_next = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt == FULL) begin
                    cnt_clr  = 1'b1;
                    stop_ok  = rxs;
                    stop_bad = !rxs;
                    r_next   = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= R_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            r_state  <= r_next;
            cnt      <= cnt_clr ? '0 : cnt + 1'b1;
            rx_valid <= stop_ok;
            if (r_state == R_START) bit_idx <= '0;
            else if (bit_take) bit_idx <= bit_idx + 1'b1;
            // LSB arrives first, so shift in from the top.
            if (bit_take) shift <= {rxs, shift[7:1]};
            if (stop_ok) rx_data <= shift;
        end
    end

    // The low nibble of '0'..'9' is the digit value itself.
    assign is_t    = (rx_data == 8'h54);
    assign is_cr   = (rx_data == 8'h0D);
    assign is_tens = (rx_data >= 8'h30) && (rx_data <= 8'h35);
    assign is_ones = (rx_data >= 8'h30) && (rx_data <= 8'h39);

    always_comb begin
        p_next = p_state;
        perr   = 1'b0;
        ld     = 1'b0;
        wr_m10 = 1'b0;
        wr_m1  = 1'b0;
        wr_s10 = 1'b0;
        wr_s1  = 1'b0;
        if (stop_bad) begin
            p_next = P_WAIT_T;
        end else if (rx_valid) begin
            if (is_t) begin
                p_next = P_M10;
            end else begin
                unique case (p_state)
                    P_WAIT_T: p_next = P_WAIT_T;
                    P_M10: begin
                        wr_m10 = is_tens;
                        perr   = !is_tens;
                        p_next = P_M1;
                    end
                    P_M1: begin
                        wr_m1  = is_ones;
                        perr   = !is_ones;
                        p_next = P_S10;
                    end
                    P_S10: begin
                        wr_s10 = is_tens;
                        perr   = !is_tens;
                        p_next = P_S1;
                    end
                    P_S1: begin
                        wr_s1  = is_ones;
                        perr   = !is_ones;
                        p_next = P_CR;
                    end
                    P_CR: begin
                        ld     = is_cr;
                        perr   = !is_cr;
                        p_next = P_WAIT_T;
                    end
                    default: p_next = P_WAIT_T;
                endcase
                if (perr) p_next = P_WAIT_T;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state   <= P_WAIT_T;
            m10_sh    <= '0;
            m1_sh     <= '0;
            s10_sh    <= '0;
            s1_sh     <= '0;
            min_tens  <= '0;
            min_ones  <= '0;
            sec_tens  <= '0;
            sec_ones  <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            p_state   <= p_next;
            load      <= ld;
            frame_err <= perr | stop_bad;
            if (wr_m10) m10_sh <= rx_data[2:0];
            if (wr_m1)  m1_sh  <= rx_data[3:0];
            if (wr_s10) s10_sh <= rx_data[2:0];
            if (wr_s1)  s1_sh  <= rx_data[3:0];
            if (ld) begin
                min_tens <= m10_sh;
                min_ones <= m1_sh;
                sec_tens <= s10_sh;
                sec_ones <= s1_sh;
            end
        end
    end
endmodule

// File: tb/tb_uart_time_set_rx.sv
// Bench for uart_time_set_rx: directed scenarios plus random
// byte streams checked against a frame-level reference model.
module tb_uart_time_set_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, load, frame_err;
    logic [2:0] min_tens, sec_tens;
    logic [3:0] min_ones, sec_ones;
    logic [15:0] dig;

    int n_cmp = 0;
    int n_bad = 0;

    uart_time_set_rx #(.CLK_FREQ(160), .BAUD(10)) dut (
        .clk(clk), .reset(reset), .RxD(RxD),
        .rx_data(rx_data), .rx_valid(rx_valid), .load(load),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign dig = {1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};

    // Observations collected on the falling edge.
    logic [7:0] got_rx[$];
    int got_load, got_ferr, lat_bad, overlap, wide;
    int cyc = 0;
    int last_v = -10;
    bit prev_load = 0, prev_ferr = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rx_valid) begin
            got_rx.push_back(rx_data);
            last_v = cyc;
        end
        if (load) begin
            got_load++;
            if (cyc != last_v + 1) lat_bad++;
        end
        if (frame_err) got_ferr++;
        if (load && frame_err) overlap++;
        if ((load && prev_load) || (frame_err && prev_ferr)) wide++;
        prev_load = load;
        prev_ferr = frame_err;
    end

    // Frame-level reference model: position within "T d d d d CR".
    int m_pos = 0;
    logic [3:0] m_sh[4];
    logic [3:0] m_dig[4];
    int m_loads, m_errs;
    logic [7:0] m_rx[$];

    task automatic model_byte(input logic [7:0] b);
        int lim;
        m_rx.push_back(b);
        if (b == 8'h54) begin
            m_pos = 1;
        end else if (m_pos >= 1 && m_pos <= 4) begin
            lim = (m_pos % 2 == 1) ? 5 : 9;
            if (b >= 8'h30 && int'(b) <= 8'h30 + lim) begin
                m_sh[m_pos-1] = 4'(b - 8'h30);
                m_pos++;
            end else begin
                m_errs++;
                m_pos = 0;
            end
        end else if (m_pos == 5) begin
            if (b == 8'h0D) begin
                m_loads++;
                m_dig = m_sh;
            end else begin
                m_errs++;
            end
            m_pos = 0;
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    endtask

    task automatic clear_obs();
        got_rx.delete();
        m_rx.delete();
        got_load = 0; got_ferr = 0; lat_bad = 0;
        overlap = 0; wide = 0;
        m_loads = 0; m_errs = 0;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        RxD = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            hold(CPB);
        end
        if (stop_ok) begin
            RxD = 1'b1;
            hold(CPB);
            model_byte(b);
        end else begin
            // Short low stop bit, then idle so the receiver settles.
            RxD = 1'b0;
            hold(CPB * 3 / 4);
            RxD = 1'b1;
            hold(3 * CPB);
            m_errs++;
            m_pos = 0;
        end
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
        hold(4);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        RxD = 1'b1;
        model_reset();
        hold(3);
        n_cmp++;
        if ({rx_data, rx_valid, load, frame_err, dig} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rx_data, rx_valid, load, frame_err, dig});
        end
        reset = 1'b1;
        hold(4);
        clear_obs();
    endtask

    task automatic test_single_byte();
        clear_obs();
        send_q('{8'hA5});
        n_cmp++;
        if (got_rx.size() !== 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d want 1", got_rx.size());
        end
        n_cmp++;
        if (rx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL single_data: got %h want a5", rx_data);
        end
        n_cmp++;
        if (got_load + got_ferr !== 0) begin
            n_bad++;
            $display("FAIL single_noload: got %0d/%0d want 0/0",
                     got_load, got_ferr);
        end
    endtask

    task automatic test_valid_frame();
        clear_obs();
        send_q('{8'h54, 8'h34, 8'h37, 8'h32, 8'h39, 8'h0D});
        n_cmp++;
        if (got_load !== 1 || lat_bad !== 0) begin
            n_bad++;
            $display("FAIL valid_load: got %0d late %0d want 1 late 0",
                     got_load, lat_bad);
        end
        n_cmp++;
        if (dig !== 16'h4729) begin
            n_bad++;
            $display("FAIL valid_digits: got %h want 4729", dig);
        end
        n_cmp++;
        if (got_rx.size() !== 6 || got_ferr !== 0) begin
            n_bad++;
            $display("FAIL valid_rx: got %0d bytes %0d errs want 6 0",
                     got_rx.size(), got_ferr);
        end
    endtask

    task automatic test_invalid_digit();
        clear_obs();
        send_q('{8'h54, 8'h36, 8'h30, 8'h30, 8'h30, 8'h0D});
        n_cmp++;
        if (got_ferr !== 1 || got_load !== 0) begin
            n_bad++;
            $display("FAIL invalid_err: got err %0d load %0d want 1 0",
                     got_ferr, got_load);
        end
        n_cmp++;
        if (dig !== 16'h4729) begin
            n_bad++;
            $display("FAIL invalid_hold: got %h want 4729", dig);
        end
    endtask

    task automatic test_restart();
        clear_obs();
        send_q('{8'h54, 8'h31, 8'h54, 8'h30, 8'h35, 8'h33, 8'h30, 8'h0D});
        n_cmp++;
        if (got_load !== 1 || got_ferr !== 0) begin
            n_bad++;
            $display("FAIL restart_pulses: got load %0d err %0d want 1 0",
                     got_load, got_ferr);
        end
        n_cmp++;
        if (dig !== 16'h0530) begin
            n_bad++;
            $display("FAIL restart_digits: got %h want 0530", dig);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        RxD = 1'b0;
        hold(4);
        RxD = 1'b1;
        hold(3 * CPB);
        n_cmp++;
        if (got_rx.size() !== 0 || got_ferr !== 0) begin
            n_bad++;
            $display("FAIL glitch: got %0d bytes %0d errs want 0 0",
                     got_rx.size(), got_ferr);
        end
    endtask

    task automatic test_reset_mid_byte();
        clear_obs();
        RxD = 1'b0;
        hold(CPB + 5);
        RxD = 1'b1;
        hold(2 * CPB);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rx_data, load, frame_err, dig} !== 26'd0) begin
            n_bad++;
            $display("FAIL midbyte_reset: got %h want 0",
                     {rx_data, load, frame_err, dig});
        end
        model_reset();
        hold(5);
        reset = 1'b1;
        hold(5);
        clear_obs();
        send_q('{8'h54, 8'h35, 8'h39, 8'h35, 8'h39, 8'h0D});
        n_cmp++;
        if (got_load !== 1 || dig !== 16'h5959) begin
            n_bad++;
            $display("FAIL after_reset_load: got %0d %h want 1 5959",
                     got_load, dig);
        end
    endtask

    task automatic test_framing_error();
        clear_obs();
        send_q('{8'h54, 8'h31, 8'h32});
        send_byte(8'h33, 1'b0);
        n_cmp++;
        if (got_ferr !== 1 || got_rx.size() !== 3) begin
            n_bad++;
            $display("FAIL framing_err: got %0d errs %0d bytes want 1 3",
                     got_ferr, got_rx.size());
        end
        send_q('{8'h54, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D});
        n_cmp++;
        if (got_load !== 1 || dig !== 16'h0000) begin
            n_bad++;
            $display("FAIL framing_recover: got %0d %h want 1 0000",
                     got_load, dig);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [15:0] want;
        clear_obs();
        for (int k = 0; k < 10; k++) begin
            q = '{8'h54,
                  8'(8'h30 + $urandom_range(0, 5)),
                  8'(8'h30 + $urandom_range(0, 9)),
                  8'(8'h30 + $urandom_range(0, 5)),
                  8'(8'h30 + $urandom_range(0, 9)),
                  8'h0D};
            case ($urandom_range(0, 3))
                0: send_q(q);
                1: send_byte(8'($urandom), 1'b1);
                2: begin
                    q[$urandom_range(1, 5)] = 8'($urandom_range(8'h36, 8'h53));
                    send_q(q);
                end
                default: send_byte(8'($urandom), 1'b0);
            endcase
        end
        send_q('{8'h54, 8'h32, 8'h38, 8'h31, 8'h37, 8'h0D});
        n_cmp++;
        if (got_rx.size() !== m_rx.size()) begin
            n_bad++;
            $display("FAIL rand_count: got %0d want %0d",
                     got_rx.size(), m_rx.size());
        end
        for (int i = 0; i < got_rx.size() && i < m_rx.size(); i++) begin
            n_cmp++;
            if (got_rx[i] !== m_rx[i]) begin
                n_bad++;
                $display("FAIL rand_byte%0d: got %h want %h",
                         i, got_rx[i], m_rx[i]);
            end
        end
        n_cmp++;
        if (got_load !== m_loads || got_ferr !== m_errs) begin
            n_bad++;
            $display("FAIL rand_pulses: got %0d/%0d want %0d/%0d",
                     got_load, got_ferr, m_loads, m_errs);
        end
        want = {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
        n_cmp++;
        if (dig !== want) begin
            n_bad++;
            $display("FAIL rand_digits: got %h want %h", dig, want);
        end
        n_cmp++;
        if (lat_bad !== 0 || overlap !== 0 || wide !== 0) begin
            n_bad++;
            $display("FAIL rand_pulse_shape: got %0d/%0d/%0d want 0/0/0",
                     lat_bad, overlap, wide);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_valid_frame();
        test_invalid_digit();
        test_restart();
        test_glitch();
        test_reset_mid_byte();
        test_framing_error();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_time_set_rx.md
Name: uart_time_set_rx

Overview:
- UART receiver plus command parser that sits directly upstream of the seconds/minutes counter.
- Deserialises bytes from RxD and recognises an ASCII "set time" frame of the form T M M S S CR.
- When a frame is valid, it presents BCD digits with a one-cycle load pulse so the counter can preset minutes and seconds.
- Malformed frames are discarded and flagged; the digit outputs are left untouched.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD, clocks per bit. Derived; must be at least 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- RxD  input  1  asynchronous serial line; idle high.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- load  output  1  one-cycle pulse on a valid complete frame.
- min_tens  output  3  minutes tens digit, 0-5.
- min_ones  output  4  minutes ones digit, 0-9.
- sec_tens  output  3  seconds tens digit, 0-5.
- sec_ones  output  4  seconds ones digit, 0-9.
- frame_err  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (reset low, asynchronous):
  - Both synchroniser flops go to 1.
  - Receiver FSM goes to R_IDLE; parser goes to P_WAIT_T.
  - All outputs go to 0.
- Synchroniser: RxD passes through 2 flops. All receiver logic uses the second flop (rxs).
- Receiver FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: when rxs=0, clear the counter and go to R_START.
  - R_START: at count CLKS_PER_BIT/2-1, sample rxs.
    - If rxs=0, go to R_DATA with the counter cleared.
    - If rxs=1, treat it as a glitch and return to R_IDLE with no output.
  - R_DATA: every CLKS_PER_BIT clocks, sample one bit. Bits are LSB first, 8 in total, then go to R_STOP.
  - R_STOP: after CLKS_PER_BIT clocks, sample the stop bit.
    - If the stop bit is 1: rx_data updates and rx_valid pulses on the next cycle (N+1, where N is the stop-sample cycle).
    - If the stop bit is 0 (framing error): rx_data/rx_valid do not change; the parser is forced to P_WAIT_T and frame_err pulses at N+1.
    - Either way, return to R_IDLE.
- Parser FSM states: P_WAIT_T, P_M10, P_M1, P_S10, P_S1, P_CR. It advances only on rx_valid.
  - P_WAIT_T: 0x54 ('T') moves to P_M10. Any other byte is ignored silently, with no frame_err.
  - P_M10 and P_S10: accept 0x30-0x35, store (byte-0x30) into a 3-bit shadow register, and advance.
  - P_M1 and P_S1: accept 0x30-0x39, store into a 4-bit shadow register, and advance.
  - P_CR: 0x0D causes load to pulse at N+2. On the same edge min_tens/min_ones/sec_tens/sec_ones take the shadow values. Then go to P_WAIT_T.
  - In any state other than P_WAIT_T:
    - A 'T' restarts the frame: go to P_M10 with no frame_err.
    - Any other invalid byte sends the parser to P_WAIT_T and pulses frame_err at N+2.
- Digit outputs change only on load and hold otherwise, including across aborted frames.
- Shadow registers never drive the outputs directly.
- load and frame_err never assert in the same cycle. Each is high for exactly 1 cycle.
- Back-to-back bytes with no idle time between stop and start bits must be received correctly.
- Reset mid-byte or mid-frame discards everything. The first valid frame after reset must load.

Test Plan:
- Simulation setup: CLK_FREQ=160, BAUD=10 (CLKS_PER_BIT=16).
- Single byte: send 0xA5 with a correct stop bit -> rx_valid pulses once; rx_data=0xA5; load=0; frame_err=0.
- Valid frame: send "T","4","7","2","9",0x0D back-to-back -> load pulses once, 2 cycles after the CR stop sample; outputs are min_tens=4, min_ones=7, sec_tens=2, sec_ones=9.
- Invalid digit: after the valid frame, send "T","6","0","0","0",CR -> frame_err pulses on the "6"; no load; digits stay 4,7,2,9. The trailing "0","0","0",CR are ignored.
- Restart and glitch:
  - Send "T","1","T","0","5","3","0",CR -> single load with outputs 0,5,3,0; no frame_err.
  - Separately, drive a 4-cycle low glitch on RxD -> no rx_valid.
- Framing error and reset:
  - Send "T","1","2" followed by a byte whose stop bit is 0 -> frame_err pulses; parser returns to P_WAIT_T; the next full frame "T0000",CR loads 0,0,0,0.
  - Separately, assert reset mid-byte -> all outputs go to 0 immediately; the next frame "T5959",CR loads 5,9,5,9.
